// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit load/store into two timed 16-bit async SRAM accesses, low half first
module sram_controller #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [2:0] WC = 3'(WAIT_CYCLES);
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0] lo_q, lo_d;
  logic [17:0] addr_q, addr_d;
  logic        req, last, active;
  assign req    = rd_en | wr_en;
  assign last   = cnt_q == WC;
  assign active = state_q == LOW || state_q == HIGH;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LOW;
        cnt_d   = 3'd0;
        wr_d    = wr_en;
        wdata_d = write_data;
        addr_d  = {17'((address - BASE_ADDR) >> 2), 1'b0};
      end
      LOW: begin
        cnt_d = last ? 3'd0 : cnt_q + 3'd1;
        if (last) begin
          state_d   = HIGH;
          addr_d[0] = 1'b1;
          lo_d      = wr_q ? lo_q : sram_dq;
        end
      end
      HIGH: begin
        cnt_d = last ? 3'd0 : cnt_q + 3'd1;
        if (last) begin
          state_d = DONE;
          rdata_d = wr_q ? rdata_q : {sram_dq, lo_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      lo_q    <= 16'd0;
      addr_q  <= 18'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
    end
  end
  assign read_data = rdata_q;
  assign sram_addr = addr_q;
  assign ready     = (state_q == IDLE && !req) || state_q == DONE;
  assign sram_ce_n = !active;
  assign sram_ub_n = !active;
  assign sram_lb_n = !active;
  assign sram_we_n = !(active && wr_q);
  assign sram_oe_n = !(active && !wr_q);
  assign sram_dq   = (active && wr_q) ? (state_q == LOW ? wdata_q[15:0] : wdata_q[31:16]) : 16'bz;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed and random loads/stores on three wait settings against a word-level memory model
module tb_sram_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  rd_v = 3'b0, wr_v = 3'b0;
  logic [31:0] addr_v [3];
  logic [31:0] wd_v [3];
  wire  [31:0] rdat_v [3];
  wire  [17:0] sa_v [3];
  wire  [2:0]  rdy_v, we_v, oe_v, ce_v, ub_v, lb_v;
  wire  [15:0] dq0, dq1, dq3;
  logic [15:0] mem [262144];
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd [3];
  logic [31:0] written [$];
  int          wc [3] = '{0, 1, 3};
  int          n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .rd_en(rd_v[0]), .wr_en(wr_v[0]), .address(addr_v[0]),
    .write_data(wd_v[0]), .read_data(rdat_v[0]), .ready(rdy_v[0]), .sram_addr(sa_v[0]),
    .sram_dq(dq0), .sram_we_n(we_v[0]), .sram_oe_n(oe_v[0]), .sram_ce_n(ce_v[0]),
    .sram_ub_n(ub_v[0]), .sram_lb_n(lb_v[0]));
  sram_controller #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd_v[1]), .wr_en(wr_v[1]), .address(addr_v[1]),
    .write_data(wd_v[1]), .read_data(rdat_v[1]), .ready(rdy_v[1]), .sram_addr(sa_v[1]),
    .sram_dq(dq1), .sram_we_n(we_v[1]), .sram_oe_n(oe_v[1]), .sram_ce_n(ce_v[1]),
    .sram_ub_n(ub_v[1]), .sram_lb_n(lb_v[1]));
  sram_controller #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .rd_en(rd_v[2]), .wr_en(wr_v[2]), .address(addr_v[2]),
    .write_data(wd_v[2]), .read_data(rdat_v[2]), .ready(rdy_v[2]), .sram_addr(sa_v[2]),
    .sram_dq(dq3), .sram_we_n(we_v[2]), .sram_oe_n(oe_v[2]), .sram_ce_n(ce_v[2]),
    .sram_ub_n(ub_v[2]), .sram_lb_n(lb_v[2]));

  assign dq1 = (!ce_v[1] && !oe_v[1] && we_v[1]) ? mem[sa_v[1]] : 16'bz;
  always @(posedge clk) if (!ce_v[1] && !we_v[1]) mem[sa_v[1]] <= dq1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes(input int k);
    return {ce_v[k], ub_v[k], lb_v[k], we_v[k], oe_v[k]};
  endfunction

  task automatic op(input int k, input bit wr, input bit rd, input logic [31:0] a,
                    input logic [31:0] d, input bit mid);
    int t, c;
    bit h;
    logic [16:0] w;
    logic [15:0] dqv;
    t = wc[k] + 1;
    w = 17'((a - 32'd1024) >> 2);
    @(negedge clk);
    wr_v[k] = wr; rd_v[k] = rd; addr_v[k] = a; wd_v[k] = d;
    if (wr && k == 1) ref_mem[int'(w)] = d;
    if (!wr && rd) exp_rd[k] = ref_mem[int'(w)];
    c = 0;
    #1;
    while (!rdy_v[k] && c < 40) begin
      h = c > t;
      if (c >= 1 && c <= 2 * t) begin
        chk("strobes_act", strobes(k), {3'b000, !wr, wr});
        chk("sram_addr", sa_v[k], {w, h});
        dqv = k == 0 ? dq0 : k == 1 ? dq1 : dq3;
        if (wr) chk("wr_dq", dqv, h ? d[31:16] : d[15:0]);
      end else chk("strobes_idle", strobes(k), 5'h1f);
      @(negedge clk);
      c++;
      if (mid && c == 2) begin
        wr_v[k] = 1'b0; rd_v[k] = 1'b0; addr_v[k] = 32'd2048;
      end
      #1;
    end
    chk("ready_low_cycles", c, 2 * t + 1);
    chk("done_strobes", strobes(k), 5'h1f);
    chk("done_read_data", rdat_v[k], exp_rd[k]);
    @(negedge clk);
    wr_v[k] = 1'b0; rd_v[k] = 1'b0;
  endtask

  initial begin
    int t;
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      addr_v[k] = 32'd0; wd_v[k] = 32'd0; exp_rd[k] = 32'd0;
    end
    #1;
    chk("rst_strobes", strobes(1), 5'h1f);
    chk("rst_read_data", rdat_v[1], 32'd0);
    chk("rst_sram_addr", sa_v[1], 18'd0);
    chk("rst_ready", rdy_v[1], 1'b1);
    @(negedge clk) rst = 1'b1;

    op(1, 1, 0, 32'd1028, 32'hDEADBEEF, 0);
    op(1, 0, 1, 32'd1028, 32'd0, 0);
    op(1, 1, 1, 32'd1024, 32'h12345678, 0);
    op(1, 0, 1, 32'd1024, 32'd0, 0);
    op(1, 1, 0, 32'd1024, 32'hCAFEF00D, 1);
    op(1, 0, 1, 32'd1024, 32'd0, 0);
    op(1, 1, 0, 32'd1020, 32'h0BADC0DE, 0);
    op(1, 0, 1, 32'd1020, 32'd0, 0);
    op(1, 0, 1, 32'd1028, 32'd0, 0);

    op(0, 1, 0, 32'd1024 + 4 * $urandom_range(0, 255), $urandom, 0);
    op(2, 1, 0, 32'd1024 + 4 * $urandom_range(0, 255), $urandom, 0);
    op(2, 1, 1, 32'd1100, 32'hA5A5_5A5A, 0);

    for (int i = 0; i < 30; i++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = 32'd1024 + 4 * $urandom_range(16, 63) + $urandom_range(0, 3);
        written.push_back(a);
        op(1, 1, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        op(1, 0, 1, a, 32'd0, 0);
      end
    end

    op(1, 0, 1, 32'd1028, 32'd0, 0);
    t = wc[1] + 1;
    @(negedge clk);
    rd_v[1] = 1'b1; addr_v[1] = 32'd1028;
    repeat (t + 1) @(negedge clk);
    #1;
    chk("pre_rst_in_high", sa_v[1], 18'd3);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) exp_rd[k] = 32'd0;
    chk("arst_strobes", strobes(1), 5'h1f);
    chk("arst_read_data", rdat_v[1], 32'd0);
    chk("arst_sram_addr", sa_v[1], 18'd0);
    chk("arst_ready_req", rdy_v[1], 1'b0);
    rd_v[1] = 1'b0;
    #1;
    chk("arst_ready_idle", rdy_v[1], 1'b1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_strobes", strobes(1), 5'h1f);
    op(1, 0, 1, 32'd1028, 32'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
